// File: rtl/decoder_3x8_if.sv
// decoder_3x8_if: select/decode bundle for decoder_3x8.
//   en        decode enable (master -> slave)
//   in[2:0]   binary select (master -> slave)
//   out[7:0]  registered one-hot decode (slave -> master)
//   out_valid registered copy of en (slave -> master)
interface decoder_3x8_if;
    logic       en;
    logic [2:0] in;
    logic [7:0] out;
    logic       out_valid;

    modport master (
        output en,
        output in,
        input  out,
        input  out_valid
    );

    modport slave (
        input  en,
        input  in,
        output out,
        output out_valid
    );
endinterface

// File: rtl/decoder_3x8.sv
// decoder_3x8: registered 3-to-8 line decoder with active-high enable.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  decoder_3x8_if.slave: en, in[2:0] in; out[7:0], out_valid out
// Parameter OUT_ACTIVE_LOW inverts the whole output word, idle value included.
// Outputs come straight from flops; there is no input-to-output comb path.
module decoder_3x8 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    decoder_3x8_if.slave  bus
);
    // XOR mask applied to the active-high decode; also equals the idle word.
    localparam logic [7:0] POL_MASK = {8{OUT_ACTIVE_LOW}};

    logic [7:0] onehot;
    logic [7:0] out_d;
    logic [7:0] out_q;
    logic       out_valid_d;
    logic       out_valid_q;

    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
        assign onehot[gi] = (bus.in == 3'(gi));
    end

    always_comb begin
        out_d       = POL_MASK;
        out_valid_d = 1'b0;
        if (bus.en) begin
            out_d       = onehot ^ POL_MASK;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= POL_MASK;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_decoder_3x8.sv
module tb_decoder_3x8;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   fail_cnt;
    int   total_cnt;

    decoder_3x8_if bus_hi ();
    decoder_3x8_if bus_lo ();

    decoder_3x8 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
        .clk (clk),
        .rst (rst),
        .bus (bus_hi.slave)
    );

    decoder_3x8 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
        .clk (clk),
        .rst (rst),
        .bus (bus_lo.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic en_v, input logic [2:0] in_v);
        bus_hi.en = en_v;
        bus_hi.in = in_v;
        bus_lo.en = en_v;
        bus_lo.in = in_v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // Checks both polarity instances against hand-computed words.
    task automatic check(input string tag, input logic [7:0] exp_hi,
                         input logic [7:0] exp_lo, input logic exp_v);
        chk8({tag, "/out_hi"}, bus_hi.out, exp_hi);
        chk1({tag, "/vld_hi"}, bus_hi.out_valid, exp_v);
        chk8({tag, "/out_lo"}, bus_lo.out, exp_lo);
        chk1({tag, "/vld_lo"}, bus_lo.out_valid, exp_v);
        $display("step %-12s en=%b in=%0d out_hi=%h out_lo=%h vld=%b",
                 tag, bus_hi.en, bus_hi.in, bus_hi.out, bus_lo.out, bus_hi.out_valid);
    endtask

    logic [7:0] sweep_hi [8];
    logic [7:0] sweep_lo [8];

    initial begin
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        sweep_hi = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        sweep_lo = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        // Reset with en=1, in=5 held: reset wins.
        rst = 1'b1;
        drive(1'b1, 3'd5);
        tick();
        tick();
        check("reset", 8'h00, 8'hFF, 1'b0);

        // Full sweep of {en,in}.
        rst = 1'b0;
        for (int v = 0; v < 16; v++) begin
            drive(v[3], v[2:0]);
            tick();
            if (v < 8) check($sformatf("sweep%0d", v), 8'h00, 8'hFF, 1'b0);
            else       check($sformatf("sweep%0d", v), sweep_hi[v-8], sweep_lo[v-8], 1'b1);
        end

        // Back-to-back selects.
        drive(1'b1, 3'd3); tick(); check("b2b_3", 8'h08, 8'hF7, 1'b1);
        drive(1'b1, 3'd6); tick(); check("b2b_6", 8'h40, 8'hBF, 1'b1);
        drive(1'b1, 3'd0); tick(); check("b2b_0", 8'h01, 8'hFE, 1'b1);

        // Enable drop and recovery.
        drive(1'b1, 3'd4); tick(); check("en_on", 8'h10, 8'hEF, 1'b1);
        drive(1'b0, 3'd4); tick(); check("en_off", 8'h00, 8'hFF, 1'b0);
        drive(1'b1, 3'd4); tick(); check("en_back", 8'h10, 8'hEF, 1'b1);

        // Reset mid-stream.
        drive(1'b1, 3'd7); tick(); check("pre_rst", 8'h80, 8'h7F, 1'b1);
        rst = 1'b1;        tick(); check("mid_rst", 8'h00, 8'hFF, 1'b0);
        rst = 1'b0;        tick(); check("post_rst", 8'h80, 8'h7F, 1'b1);

        // Polarity directed case.
        drive(1'b1, 3'd2); tick(); check("pol_in2", 8'h04, 8'hFB, 1'b1);
        drive(1'b0, 3'd2); tick(); check("pol_idle", 8'h00, 8'hFF, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/decoder_3x8.md
Name: decoder_3x8

Overview:
- Registered 3-to-8 line decoder with active-high enable.
- Converts a 3-bit binary select into a one-hot 8-bit word, one cycle after sampling.
- Used as a generic address/select decoder feeding chip-select or strobe logic in the datapath.
- All outputs come from flops, giving glitch-free, timing-clean select lines.

Parameters:
- OUT_ACTIVE_LOW, 0, polarity of out.
  - 0: selected bit = 1, others = 0.
  - 1: full output word inverted (selected bit = 0, others = 1), including the reset/idle value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  decode enable; sampled on the rising edge of clk.
- in  input  3  binary select, 0..7; sampled on the rising edge of clk.
- out  output  8  registered one-hot decode of in (polarity per OUT_ACTIVE_LOW).
- out_valid  output  1  registered copy of en: out reflects an enabled decode.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: when rst=1 at a rising edge of clk:
  - out <= idle value: 8'h00 when OUT_ACTIVE_LOW=0, 8'hFF when OUT_ACTIVE_LOW=1.
  - out_valid <= 0.
  - rst has priority over en/in at the same edge.
- Decode (rst=0, en=1) at a rising edge: out <= (8'b1 << in) at active-high polarity; out_valid <= 1.
  - in=0 gives 8'b0000_0001; in=7 gives 8'b1000_0000.
- Disabled (rst=0, en=0) at a rising edge:
  - out <= idle value, regardless of in.
  - out_valid <= 0.
- Latency: exactly 1 cycle from sampled en/in to out/out_valid. No combinational path from inputs to outputs.
- Throughput: a new decode every cycle; back-to-back changes of in are each reflected on the following cycle.
- Invariant: at active-high polarity, out has exactly one bit set when out_valid=1, and all zeros when out_valid=0.
  - Mirror invariant for OUT_ACTIVE_LOW=1 (exactly one zero bit / all ones).
- Toggling en mid-stream: out goes to idle the cycle after en falls and resumes decoding the cycle after en rises. No other state is kept.
- Reset asserted mid-operation: out and out_valid return to idle on the next edge. Decoding resumes on the first edge with rst=0 and en=1.
- Before the first clock edge, output values are undefined. A bench applies rst for at least one cycle before checking.
- in is always a legal 3-bit value; no out-of-range handling is required.

Test Plan:
- Reset: hold rst=1 with en=1, in=5 for 2 cycles -> out=8'h00, out_valid=0 (8'hFF, 0 with OUT_ACTIVE_LOW=1).
- Full sweep: after reset, drive {en,in}=0..15, one value per cycle.
  - Each cycle after {en,in}=0..7 -> out=8'h00, out_valid=0.
  - After {en,in}=8..15 -> out=8'h01,02,04,08,10,20,40,80 in order, out_valid=1.
- Latency/back-to-back: en=1, in changes 3 -> 6 -> 0 on consecutive edges -> out reads 8'h08, 8'h40, 8'h01 on the following consecutive cycles.
- Enable drop: en=1, in=4 (out=8'h10), then en=0 with in=4 held -> next cycle out=8'h00, out_valid=0. Then en=1 -> out=8'h10 one cycle later.
- Reset mid-stream: decoding in=7 (out=8'h80), assert rst=1 for one edge with en=1 -> out=8'h00. Release rst -> out=8'h80 on the next edge.
- Polarity: OUT_ACTIVE_LOW=1, en=1, in=2 -> out=8'hFB, out_valid=1. en=0 -> out=8'hFF.
